// File: rtl/debounce_edge_det.sv
// Synchronizer + debounce FSM producing a clean registered level with rise/fall pulses.
// Optional aborted-transition counter on o_glitch_cnt when DEBOUNCE_GLITCH_CNT_EN is defined.
module debounce_edge_det #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_d,
    output logic       o_q,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] o_glitch_cnt
`endif
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             q_reg, q_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_d};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // Any reversion of s while waiting drops straight back to IDLE with a cleared count.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            IDLE_LO: begin
                if (s) begin
                    state_next = WAIT_HI;
                    cnt_next   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HI;
                    q_next     = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_next = WAIT_LO;
                    cnt_next   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LO;
                    q_next     = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE_LO;
            cnt_reg   <= '0;
            q_reg     <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign o_q    = q_reg;
    assign o_rise = rise_reg;
    assign o_fall = fall_reg;
    assign o_busy = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_reg;
    logic       abort;

    assign abort = ((state_reg == WAIT_HI) && !s) || ((state_reg == WAIT_LO) && s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            glitch_reg <= 8'd0;
        end else if (abort && (glitch_reg != 8'hFF)) begin
            glitch_reg <= glitch_reg + 8'd1;
        end
    end

    assign o_glitch_cnt = glitch_reg;
`endif

endmodule

// File: tb/tb_debounce_edge_det.sv
// Scoreboard bench for debounce_edge_det (SYNC_STAGES=2, DEBOUNCE_CYC=4, CNT_W=4).
// Expected pulses are queued when stimulus is applied and matched as the DUT emits them.
module tb_debounce_edge_det;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_d;
    logic       o_q, o_rise, o_fall, o_busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] o_glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    typedef struct packed {
        int   edge_no;
        logic rise;
    } exp_t;
    exp_t exp_q[$];

    debounce_edge_det #(
        .SYNC_STAGES (2),
        .DEBOUNCE_CYC(4),
        .CNT_W       (4)
    ) dut (
        .i_clk (clk),
        .i_rst (i_rst),
        .i_d   (i_d),
        .o_q   (o_q),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_busy(o_busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .o_glitch_cnt(o_glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Pulse scoreboard: every observed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_rise && o_fall) begin
            n_checks++;
            n_fail++;
            $display("FAIL both_pulses edge %0d: rise=%b fall=%b, required never both high", edge_cnt, o_rise, o_fall);
        end else if (o_rise || o_fall) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse edge %0d: rise=%b fall=%b, required none", edge_cnt, o_rise, o_fall);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.edge_no !== edge_cnt || e.rise !== o_rise) begin
                    n_fail++;
                    $display("FAIL pulse edge %0d rise=%b, required edge %0d rise=%b", edge_cnt, o_rise, e.edge_no, e.rise);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        i_rst = 1'b1;
        i_d   = 1'b1;
        #1;
        n_checks += 4;
        if (o_q !== 1'b0)    begin n_fail++; $display("FAIL reset_async_q: got %b want 0", o_q); end
        if (o_rise !== 1'b0) begin n_fail++; $display("FAIL reset_async_rise: got %b want 0", o_rise); end
        if (o_fall !== 1'b0) begin n_fail++; $display("FAIL reset_async_fall: got %b want 0", o_fall); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy: got %b want 0", o_busy); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (o_glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_async_glitch: got %0d want 0", o_glitch_cnt); end
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 2;
        if (o_q !== 1'b0)    begin n_fail++; $display("FAIL reset_held_q: got %b want 0", o_q); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_held_busy: got %b want 0", o_busy); end
        i_d = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (o_q !== 1'b0)    begin n_fail++; $display("FAIL reset_idle_q: got %b want 0", o_q); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", o_busy); end
        $display("test_reset done: q=%b busy=%b", o_q, o_busy);
    endtask

    task automatic test_clean_rise();
        int base;
        @(negedge clk);
        i_d  = 1'b1;
        base = edge_cnt + 1;
        exp_q.push_back('{edge_no: base + 6, rise: 1'b1});
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks += 2;
            if (o_busy !== (k >= 2 && k <= 5)) begin
                n_fail++; $display("FAIL rise_busy edge +%0d: got %b want %b", k, o_busy, (k >= 2 && k <= 5));
            end
            if (o_q !== (k >= 6)) begin
                n_fail++; $display("FAIL rise_q edge +%0d: got %b want %b", k, o_q, (k >= 6));
            end
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rise_missing: %0d pulses pending, want 0", exp_q.size()); exp_q.delete(); end
        $display("test_clean_rise done: q=%b", o_q);
    endtask

    task automatic test_clean_fall();
        int base;
        @(negedge clk);
        i_d  = 1'b0;
        base = edge_cnt + 1;
        exp_q.push_back('{edge_no: base + 6, rise: 1'b0});
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks += 2;
            if (o_busy !== (k >= 2 && k <= 5)) begin
                n_fail++; $display("FAIL fall_busy edge +%0d: got %b want %b", k, o_busy, (k >= 2 && k <= 5));
            end
            if (o_q !== (k < 6)) begin
                n_fail++; $display("FAIL fall_q edge +%0d: got %b want %b", k, o_q, (k < 6));
            end
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL fall_missing: %0d pulses pending, want 0", exp_q.size()); exp_q.delete(); end
        $display("test_clean_fall done: q=%b", o_q);
    endtask

    task automatic test_bounce();
        int base;
        @(negedge clk);
        i_d  = 1'b1;
        base = edge_cnt + 1;
        // Abort seen at edge 4; requalification enters WAIT at edge 5, so commit lands on edge 9.
        exp_q.push_back('{edge_no: base + 9, rise: 1'b1});
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            i_d = (k == 1) ? 1'b0 : 1'b1;
            n_checks++;
            if (o_q !== (k >= 9)) begin
                n_fail++; $display("FAIL bounce_q edge +%0d: got %b want %b", k, o_q, (k >= 9));
            end
            if (k == 4) begin
                n_checks++;
                if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bounce_abort_busy: got %b want 0", o_busy); end
            end
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bounce_missing: %0d pulses pending, want 0", exp_q.size()); exp_q.delete(); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (o_glitch_cnt !== 8'd1) begin n_fail++; $display("FAIL bounce_glitch: got %0d want 1", o_glitch_cnt); end
`endif
        $display("test_bounce done: q=%b", o_q);
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge clk);
        i_d  = 1'b1;
        base = edge_cnt + 1;
        repeat (5) @(negedge clk);
        i_rst = 1'b1;
        #1;
        n_checks += 2;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
        if (o_q !== 1'b0)    begin n_fail++; $display("FAIL midrst_q: got %b want 0", o_q); end
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_held: got %b want 0", o_busy); end
        i_rst = 1'b0;
        exp_q.push_back('{edge_no: base + 12, rise: 1'b1});
        for (int k = 6; k <= 14; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_q !== (k >= 12)) begin
                n_fail++; $display("FAIL midrst_q edge +%0d: got %b want %b", k, o_q, (k >= 12));
            end
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_missing: %0d pulses pending, want 0", exp_q.size()); exp_q.delete(); end
        $display("test_reset_mid done: q=%b", o_q);
    endtask

    task automatic test_glitch_sat();
        for (int p = 0; p < 300; p++) begin
            @(negedge clk);
            i_d = 1'b1;
            @(negedge clk);
            i_d = 1'b0;
            repeat (2) @(negedge clk);
            if (p == 9 || p == 299) begin
                @(negedge clk);
                n_checks++;
                if (o_q !== 1'b0) begin n_fail++; $display("FAIL glitch_q after %0d pulses: got %b want 0", p + 1, o_q); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
                n_checks++;
                if (o_glitch_cnt !== ((p == 9) ? 8'd10 : 8'd255)) begin
                    n_fail++; $display("FAIL glitch_cnt after %0d pulses: got %0d want %0d", p + 1, o_glitch_cnt, (p == 9) ? 10 : 255);
                end
`endif
            end
        end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", o_busy); end
        $display("test_glitch_sat done: q=%b", o_q);
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_bounce();
        test_clean_fall();
        test_reset_mid();
        test_clean_fall();
        test_glitch_sat();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_pending: %0d pulses pending, want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
